feature_loader_pp: RTL and testbench

- Double-buffered (ping-pong), multi-lane staging buffer that feeds per-element features to the compute array.
- A producer streams LANES elements per beat into the shadow bank using burst auto-increment addressing, per-lane masking and wrap-around.
- The consumer reads the full active bank in parallel on data_o and swaps banks on command, so the array computes on one bank while the next set loads.

---
 rtl/feature_loader_pp.sv | 175 +++++++++++++++++
 tb/tb_feature_loader_pp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/feature_loader_pp.sv
// Ping-pong multi-lane staging buffer: a producer fills the shadow bank with masked,
// auto-incrementing, wrapping bursts while the compute array reads the active bank.
module feature_loader_pp #(
    parameter int ELEM_W   = 8,
    parameter int NUM_ELEM = 128,
    parameter int LANES    = 32,
    parameter int ADDR_W   = $clog2(NUM_ELEM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start_i,
    input  logic [ADDR_W-1:0]            cfg_base_i,
    input  logic [ADDR_W:0]              cfg_len_i,
    input  logic                         cfg_clear_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LANES*ELEM_W-1:0]      in_data_i,
    input  logic [LANES-1:0]             in_mask_i,
    output logic                         load_done_o,
    input  logic                         swap_i,
    output logic                         bank_sel_o,
    output logic                         out_valid_o,
    output logic [NUM_ELEM*ELEM_W-1:0]   data_o
);

    localparam logic [ADDR_W:0] NUM_ELEM_C = (ADDR_W+1)'(NUM_ELEM);
    localparam logic [ADDR_W:0] LANES_C    = (ADDR_W+1)'(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ELEM_W-1:0]   r_bank [2][NUM_ELEM];
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_rem;
    logic                r_bank_sel;
    logic                r_out_valid;

    logic                w_shadow;
    logic                w_accept;
    logic [ADDR_W:0]     w_len_clamped;
    logic [ADDR_W:0]     w_n;
    logic [ADDR_W-1:0]   w_addr    [LANES];
    logic                w_lane_we [LANES];

    assign w_shadow    = ~r_bank_sel;
    assign in_ready_o  = (r_state == S_LOAD);
    assign load_done_o = (r_state == S_FULL);
    assign w_accept    = in_valid_i & in_ready_o;
    assign bank_sel_o  = r_bank_sel;
    assign out_valid_o = r_out_valid;

    // Length clamp at start and elements consumed by the current beat.
    always_comb begin
        w_len_clamped = cfg_len_i;
        w_n           = r_rem;
        if (cfg_len_i > NUM_ELEM_C) begin
            w_len_clamped = NUM_ELEM_C;
        end else begin
            w_len_clamped = cfg_len_i;
        end
        if (r_rem < LANES_C) begin
            w_n = r_rem;
        end else begin
            w_n = LANES_C;
        end
    end

    // Per-lane target address and write enable; masked-off lanes still consume an address.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_addr[k]    = r_ptr + ADDR_W'(k);
            w_lane_we[k] = 1'b0;
            if (w_accept && ((ADDR_W+1)'(k) < w_n) && in_mask_i[k]) begin
                w_lane_we[k] = 1'b1;
            end else begin
                w_lane_we[k] = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start_i) begin
                    w_state_nxt = (w_len_clamped != '0) ? S_LOAD : S_FULL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_accept && (r_rem == w_n)) begin
                    w_state_nxt = S_FULL;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_FULL: begin
                if (swap_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FULL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bank storage, burst pointer and bank selection; writes only ever target the shadow bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_ptr       <= '0;
            r_rem       <= '0;
            r_bank_sel  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start_i) begin
                        r_ptr <= cfg_base_i;
                        r_rem <= w_len_clamped;
                        if (cfg_clear_i) begin
                            for (int i = 0; i < NUM_ELEM; i++) begin
                                r_bank[w_shadow][i] <= '0;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (w_lane_we[k]) begin
                                r_bank[w_shadow][w_addr[k]] <= in_data_i[k*ELEM_W +: ELEM_W];
                            end
                        end
                        r_ptr <= r_ptr + w_n[ADDR_W-1:0];
                        r_rem <= r_rem - w_n;
                    end
                end
                S_FULL: begin
                    if (swap_i) begin
                        r_bank_sel  <= ~r_bank_sel;
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_out
        assign data_o[gi*ELEM_W +: ELEM_W] = r_bank[r_bank_sel][gi];
    end

endmodule

// File: tb/tb_feature_loader_pp.sv
// Directed bench for feature_loader_pp: full load, partial beat, wrap with mask,
// clear/zero-length and mid-operation events against hand-built expected banks.
module tb_feature_loader_pp;

    localparam int ELEM_W   = 8;
    localparam int NUM_ELEM = 128;
    localparam int LANES    = 32;
    localparam int ADDR_W   = 7;
    localparam int DW       = NUM_ELEM*ELEM_W;

    logic                      clk;
    logic                      rst;
    logic                      cfg_start_i;
    logic [ADDR_W-1:0]         cfg_base_i;
    logic [ADDR_W:0]           cfg_len_i;
    logic                      cfg_clear_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [LANES*ELEM_W-1:0]   in_data_i;
    logic [LANES-1:0]          in_mask_i;
    logic                      load_done_o;
    logic                      swap_i;
    logic                      bank_sel_o;
    logic                      out_valid_o;
    logic [DW-1:0]             data_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [ELEM_W-1:0] exp_mem [NUM_ELEM];

    feature_loader_pp #(
        .ELEM_W(ELEM_W), .NUM_ELEM(NUM_ELEM), .LANES(LANES)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_start_i(cfg_start_i), .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i),
        .cfg_clear_i(cfg_clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_mask_i(in_mask_i), .load_done_o(load_done_o), .swap_i(swap_i),
        .bank_sel_o(bank_sel_o), .out_valid_o(out_valid_o), .data_o(data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int idx;
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            idx = 0;
            for (int i = NUM_ELEM-1; i >= 0; i--) begin
                if (obs[i*ELEM_W +: ELEM_W] !== exp[i*ELEM_W +: ELEM_W]) idx = i;
            end
            $display("FAIL %s: elem %0d got %0h expected %0h", tag, idx,
                     obs[idx*ELEM_W +: ELEM_W], exp[idx*ELEM_W +: ELEM_W]);
        end
    endtask

    function automatic logic [DW-1:0] pack_exp();
        logic [DW-1:0] v;
        for (int i = 0; i < NUM_ELEM; i++) v[i*ELEM_W +: ELEM_W] = exp_mem[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int base, input int len, input logic clr);
        cfg_start_i = 1'b1;
        cfg_base_i  = ADDR_W'(base);
        cfg_len_i   = (ADDR_W+1)'(len);
        cfg_clear_i = clr;
        tick();
        cfg_start_i = 1'b0;
        cfg_clear_i = 1'b0;
    endtask

    task automatic set_lanes(input int first, input int step);
        for (int k = 0; k < LANES; k++) in_data_i[k*ELEM_W +: ELEM_W] = ELEM_W'(first + step*k);
    endtask

    task automatic do_swap();
        swap_i = 1'b1;
        tick();
        swap_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_start_i = 1'b0; cfg_base_i = '0; cfg_len_i = '0; cfg_clear_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = '0; in_mask_i = '0; swap_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();

        // 1: reset state
        check_val("rst_data", data_o, '0);
        check_val("rst_oval", DW'(out_valid_o), '0);
        check_val("rst_rdy",  DW'(in_ready_o), '0);
        check_val("rst_sel",  DW'(bank_sel_o), '0);
        check_val("rst_done", DW'(load_done_o), '0);

        // 2: full 4-beat load, element i = i
        start(0, 128, 1'b0);
        check_val("t2_rdy", DW'(in_ready_o), DW'(1));
        in_mask_i = '1;
        for (int b = 0; b < 4; b++) begin
            in_valid_i = 1'b1;
            set_lanes(b*LANES, 1);
            tick();
            if (b == 1) check_val("t2_hold", data_o, '0);
            if (b < 3) check_val("t2_notdone", DW'(load_done_o), '0);
        end
        in_valid_i = 1'b0;
        check_val("t2_done", DW'(load_done_o), DW'(1));
        check_val("t2_rdy0", DW'(in_ready_o), '0);
        check_val("t2_prev", data_o, '0);
        do_swap();
        for (int i = 0; i < NUM_ELEM; i++) exp_mem[i] = ELEM_W'(i);
        check_val("t2_data", data_o, pack_exp());
        check_val("t2_sel",  DW'(bank_sel_o), DW'(1));
        check_val("t2_oval", DW'(out_valid_o), DW'(1));

        // 3: partial second beat into bank 0
        start(0, 40, 1'b0);
        set_lanes(8'hAA, 0);
        in_valid_i = 1'b1;
        tick();
        check_val("t3_hold", data_o, pack_exp());
        check_val("t3_rdy", DW'(in_ready_o), DW'(1));
        tick();
        in_valid_i = 1'b0;
        check_val("t3_done", DW'(load_done_o), DW'(1));
        check_val("t3_hold2", data_o, pack_exp());
        do_swap();
        for (int i = 0; i < NUM_ELEM; i++) exp_mem[i] = (i < 40) ? 8'hAA : 8'h00;
        check_val("t3_data", data_o, pack_exp());
        check_val("t3_sel", DW'(bank_sel_o), '0);

        // 4: wrap with mask into bank 1 (holds i)
        start(120, 16, 1'b0);
        set_lanes(8'h10, 1);
        in_mask_i  = 32'h0000_00F0;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        in_mask_i  = '1;
        check_val("t4_done", DW'(load_done_o), DW'(1));
        do_swap();
        for (int i = 0; i < NUM_ELEM; i++) exp_mem[i] = ELEM_W'(i);
        for (int i = 124; i < 128; i++) exp_mem[i] = ELEM_W'(8'h10 + (i - 120));
        check_val("t4_data", data_o, pack_exp());
        check_val("t4_sel", DW'(bank_sel_o), DW'(1));

        // 5: clear + zero length into bank 0, with valid held in FULL
        start(5, 0, 1'b1);
        check_val("t5_done", DW'(load_done_o), DW'(1));
        in_valid_i = 1'b1;
        set_lanes(8'hFF, 0);
        tick();
        check_val("t5_rdy", DW'(in_ready_o), '0);
        tick();
        in_valid_i = 1'b0;
        do_swap();
        check_val("t5_data", data_o, '0);
        check_val("t5_sel", DW'(bank_sel_o), '0);

        // 6: swap ignored in IDLE and LOAD, reset mid-load, swap+start in FULL
        do_swap();
        check_val("t6_idle_swap", DW'(bank_sel_o), '0);
        start(0, 128, 1'b0);
        do_swap();
        check_val("t6_load_swap", DW'(bank_sel_o), '0);
        check_val("t6_load_rdy", DW'(in_ready_o), DW'(1));
        set_lanes(8'h55, 0);
        in_valid_i = 1'b1;
        tick(); tick();
        in_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_rst_rdy",  DW'(in_ready_o), '0);
        check_val("t6_rst_done", DW'(load_done_o), '0);
        check_val("t6_rst_oval", DW'(out_valid_o), '0);
        check_val("t6_rst_data", data_o, '0);
        start(0, 0, 1'b0);
        cfg_start_i = 1'b1;
        cfg_len_i   = 8'd64;
        do_swap();
        cfg_start_i = 1'b0;
        check_val("t6_ss_sel",  DW'(bank_sel_o), DW'(1));
        check_val("t6_ss_rdy",  DW'(in_ready_o), '0);
        check_val("t6_ss_done", DW'(load_done_o), '0);
        check_val("t6_ss_oval", DW'(out_valid_o), DW'(1));
        check_val("t6_ss_data", data_o, '0);
        tick();
        check_val("t6_idle_rdy", DW'(in_ready_o), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
